// File: rtl/busca_pkg.sv
// Shared types and constants for the instruction fetch unit (unidade_busca).
package busca_pkg;

  localparam int DATA_WIDTH_PADRAO = 32;
  localparam int DEPTH_PADRAO      = 128;

  localparam logic [DATA_WIDTH_PADRAO-1:0] NOP = '0;

  typedef enum logic [1:0] {
    INICIO,
    BUSCA,
    PARADO,
    ERRO
  } estado_t;

endpackage

// File: rtl/banco_instrucoes.sv
// Instruction storage: one synchronous write port, one asynchronous read port.
// Contents are never cleared; a same-edge write is seen by the reader only after that edge.
module banco_instrucoes
  import busca_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_PADRAO,
  parameter int DEPTH      = DEPTH_PADRAO,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/unidade_busca.sv
// Instruction fetch unit: PC sequencing, branch, stall, halt and a registered fetched word.
// Optional feature macro ERRO_ENDERECO_EN: out-of-range fetch/branch faults into ERRO instead of wrapping.
module unidade_busca
  import busca_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_PADRAO,
  parameter int DEPTH      = DEPTH_PADRAO,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  stall,
  input  logic                  desvio,
  input  logic [ADDR_WIDTH-1:0] alvo_desvio,
  input  logic                  halt,
  input  logic                  prog_we,
  input  logic [ADDR_WIDTH-1:0] prog_addr,
  input  logic [DATA_WIDTH-1:0] prog_data,
  output logic [ADDR_WIDTH-1:0] endereco,
  output logic [DATA_WIDTH-1:0] instrucao_saida,
  output logic                  instrucao_valida,
  output logic                  erro
);

  // PC carries one extra bit so that stepping past the last word is observable.
  localparam int PC_W = ADDR_WIDTH + 1;
  localparam logic [PC_W-1:0] DEPTH_PC  = PC_W'(DEPTH);
  localparam logic [PC_W-1:0] ULTIMO_PC = PC_W'(DEPTH - 1);

  estado_t               estado_q, estado_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic                  valida_q, valida_d;
  logic [DATA_WIDTH-1:0] rd_data;
  logic [PC_W-1:0]       alvo_ext;
  logic                  mem_we;

  assign alvo_ext = {1'b0, alvo_desvio};

`ifdef ERRO_ENDERECO_EN
  logic erro_q, erro_d;

  assign mem_we = prog_we & ({1'b0, prog_addr} < DEPTH_PC);
  assign erro   = erro_q;
`else
  assign mem_we = prog_we;
  assign erro   = 1'b0;
`endif

  banco_instrucoes #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_banco (
    .clock (clock),
    .we    (mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q[ADDR_WIDTH-1:0]),
    .rdata (rd_data)
  );

  always_comb begin
    estado_d = estado_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    valida_d = valida_q;
`ifdef ERRO_ENDERECO_EN
    erro_d   = erro_q;
`endif
    unique case (estado_q)
      INICIO: estado_d = BUSCA;
      BUSCA: begin
        if (halt) begin
          estado_d = PARADO;
          valida_d = 1'b0;
        end else if (desvio) begin
          // A taken branch always costs one bubble, even when stall is also asserted.
          valida_d = 1'b0;
`ifdef ERRO_ENDERECO_EN
          if (alvo_ext >= DEPTH_PC) begin
            estado_d = ERRO;
            erro_d   = 1'b1;
          end else begin
            pc_d = alvo_ext;
          end
`else
          pc_d = alvo_ext;
`endif
        end else if (!stall) begin
`ifdef ERRO_ENDERECO_EN
          if (pc_q >= DEPTH_PC) begin
            estado_d = ERRO;
            erro_d   = 1'b1;
            valida_d = 1'b0;
          end else begin
            instr_d  = rd_data;
            valida_d = 1'b1;
            pc_d     = pc_q + 1'b1;
          end
`else
          instr_d  = rd_data;
          valida_d = 1'b1;
          pc_d     = (pc_q == ULTIMO_PC) ? '0 : pc_q + 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado_q <= INICIO;
      pc_q     <= '0;
      instr_q  <= DATA_WIDTH'(NOP);
      valida_q <= 1'b0;
`ifdef ERRO_ENDERECO_EN
      erro_q   <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      valida_q <= valida_d;
`ifdef ERRO_ENDERECO_EN
      erro_q   <= erro_d;
`endif
    end
  end

  assign endereco         = pc_q[ADDR_WIDTH-1:0];
  assign instrucao_saida  = instr_q;
  assign instrucao_valida = valida_q;

endmodule

// File: tb/tb_unidade_busca.sv
// Scoreboard bench for unidade_busca: directed scenarios followed by randomized stimulus.
module tb_unidade_busca;

  localparam int DW    = 32;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);
`ifdef ERRO_ENDERECO_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset_n, stall, desvio, halt, prog_we;
  logic [AW-1:0] alvo_desvio, prog_addr;
  logic [DW-1:0] prog_data;
  logic [AW-1:0] endereco;
  logic [DW-1:0] instrucao_saida;
  logic          instrucao_valida, erro;

  unidade_busca #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .stall            (stall),
    .desvio           (desvio),
    .alvo_desvio      (alvo_desvio),
    .halt             (halt),
    .prog_we          (prog_we),
    .prog_addr        (prog_addr),
    .prog_data        (prog_data),
    .endereco         (endereco),
    .instrucao_saida  (instrucao_saida),
    .instrucao_valida (instrucao_valida),
    .erro             (erro)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [AW-1:0] endereco;
    logic          valida;
    logic [DW-1:0] instr;
    logic          erro;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   ciclo = 0;

  // Reference model: a mode name, an integer PC and a plain word array.
  string         m_modo = "reset";
  int            m_pc = 0;
  logic [DW-1:0] m_out = '0;
  bit            m_val = 0;
  bit            m_erro = 0;
  logic [DW-1:0] m_mem [DEPTH];

  task automatic step(input bit rn, input bit st, input bit dv, input int alvo,
                      input bit hl, input bit we, input int wa, input logic [DW-1:0] wd);
    exp_t e;
    reset_n     = rn;
    stall       = st;
    desvio      = dv;
    alvo_desvio = AW'(alvo);
    halt        = hl;
    prog_we     = we;
    prog_addr   = AW'(wa);
    prog_data   = wd;
    if (!rn) begin
      m_modo = "inicio"; m_pc = 0; m_out = '0; m_val = 0; m_erro = 0;
    end else if (m_modo == "inicio") begin
      m_modo = "busca";
    end else if (m_modo == "busca") begin
      if (hl) begin
        m_modo = "parado"; m_val = 0;
      end else if (dv) begin
        m_val = 0;
        if (ERR_EN && alvo >= DEPTH) begin m_modo = "erro"; m_erro = 1; end
        else m_pc = alvo;
      end else if (!st) begin
        if (ERR_EN && m_pc >= DEPTH) begin
          m_modo = "erro"; m_erro = 1; m_val = 0;
        end else begin
          m_out = m_mem[m_pc]; m_val = 1;
          m_pc = ERR_EN ? m_pc + 1 : (m_pc + 1) % DEPTH;
        end
      end
    end
    // Write lands after the read of this cycle, so a same-address fetch sees the old word.
    if (we && wa < DEPTH) m_mem[wa] = wd;
    e.endereco = AW'(m_pc % (1 << AW));
    e.valida   = m_val;
    e.instr    = m_out;
    e.erro     = m_erro;
    sb.push_back(e);
    @(posedge clock);
    #1;
    ciclo++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 0, '0);
  endtask

  // Monitor: one expected entry per clock edge, compared away from the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (endereco !== e.endereco || instrucao_valida !== e.valida ||
            instrucao_saida !== e.instr || erro !== e.erro) begin
          n_err++;
          $display("FAIL saida ciclo=%0d got end=%0d val=%b instr=%h erro=%b expected end=%0d val=%b instr=%h erro=%b",
                   ciclo, endereco, instrucao_valida, instrucao_saida, erro,
                   e.endereco, e.valida, e.instr, e.erro);
        end else if (instrucao_valida) begin
          $display("fetch ciclo=%0d endereco=%0d instr=%h", ciclo, endereco, instrucao_saida);
        end
      end
    end
  end

  initial begin
    logic [DW-1:0] prog [4];
    prog[0] = 32'h0880_1000; prog[1] = 32'h08C0_1000;
    prog[2] = 32'h0900_1000; prog[3] = 32'h0940_1000;

    // Program load during reset; the four reference words at 0..3, random words elsewhere.
    for (int a = 0; a < DEPTH; a++)
      step(0, 0, 0, 0, 0, 1, a, (a < 4) ? prog[a] : DW'($urandom));

    // INICIO cycle, then words 0..3 with endereco 1..4.
    run(5);

    // Stall at endereco=2 for three cycles.
    step(0, 0, 0, 0, 0, 0, 0, '0);
    run(3);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, 0, '0);
    // Advance to endereco=3, then branch to 0 with stall also asserted.
    run(1);
    step(1, 1, 1, 0, 0, 0, 0, '0);
    run(2);

    // Halt at endereco=2, inputs ignored for ten cycles, then reset.
    step(0, 0, 0, 0, 0, 0, 0, '0);
    run(3);
    step(1, 0, 0, 0, 1, 0, 0, '0);
    for (int i = 0; i < 10; i++)
      step(1, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), 0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 0, 0, '0);

    // Overwrite address 1 while it is being fetched, then refetch it.
    run(2);
    step(1, 0, 0, 0, 0, 1, 1, 32'hDEAD_BEEF);
    step(1, 0, 1, 1, 0, 0, 0, '0);
    run(2);

    // Fetch past the last word: wrap (or fault with the error feature).
    step(1, 0, 1, DEPTH - 1, 0, 0, 0, '0);
    run(4);

    // Randomized traffic, including resets mid-stall/mid-branch and program writes.
    for (int i = 0; i < 500; i++) begin
      bit rn, st, dv, hl, we;
      rn = ($urandom_range(0, 99) >= 3);
      st = ($urandom_range(0, 99) < 30);
      dv = ($urandom_range(0, 99) < 12);
      hl = ($urandom_range(0, 99) < 2);
      we = ($urandom_range(0, 99) < 20);
      step(rn, st, dv, $urandom_range(0, DEPTH - 1), hl, we,
           $urandom_range(0, DEPTH - 1), DW'($urandom));
    end

    @(negedge clock);
    #1;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
